// File: rtl/pipeline_stall_ctrl_if.sv
// pipeline_stall_ctrl_if: fetch/interlock inputs and IF/OF, OF/EX latch outputs of the stall controller
interface pipeline_stall_ctrl_if #(parameter int XLEN = 32);
  logic            is_data_interlock;
  logic            is_branch_taken;
  logic [XLEN-1:0] if_ir;
  logic [XLEN-1:0] if_pc;
  logic            pc_we;
  logic [XLEN-1:0] of_ir;
  logic [XLEN-1:0] of_pc;
  logic            of_valid;
  logic [XLEN-1:0] ex_ir;
  logic [XLEN-1:0] ex_pc;
  logic            ex_valid;
  logic            stall_o;
  logic            flush_o;
  logic            stall_timeout;
  modport master (
    output is_data_interlock, is_branch_taken, if_ir, if_pc,
    input  pc_we, of_ir, of_pc, of_valid, ex_ir, ex_pc, ex_valid, stall_o, flush_o, stall_timeout
  );
  modport slave (
    input  is_data_interlock, is_branch_taken, if_ir, if_pc,
    output pc_we, of_ir, of_pc, of_valid, ex_ir, ex_pc, ex_valid, stall_o, flush_o, stall_timeout
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// pipeline_stall_ctrl: load-use stall / branch flush control of the IF/OF and OF/EX latches.
// Optional STALL_PERF_CNT_EN adds free-running stall-cycle and flush-event counters.
module pipeline_stall_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              MAX_STALL = 4,
  parameter logic [XLEN-1:0] NOP_IR    = 32'h68000000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  pipeline_stall_ctrl_if.slave p
`ifdef STALL_PERF_CNT_EN
  ,
  output logic [31:0]          perf_stall_cycles,
  output logic [31:0]          perf_flush_events
`endif
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  localparam logic [3:0] MAX_CNT = 4'(MAX_STALL);
  state_t     state, state_nx;
  logic       do_flush, do_stall;
  logic [3:0] stall_cnt, cnt_nx;
  // A squashed instruction in OF has no real sources, so its interlock is ignored.
  always_comb begin
    do_flush  = p.is_branch_taken;
    do_stall  = p.is_data_interlock && p.of_valid && !p.is_branch_taken;
    state_nx  = do_flush ? FLUSH : do_stall ? STALL : RUN;
    cnt_nx    = !do_stall ? 4'd0 : (stall_cnt == 4'hf) ? stall_cnt : stall_cnt + 4'd1;
    p.pc_we   = !do_stall;
    p.stall_o = state == STALL;
    p.flush_o = state == FLUSH;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state           <= RUN;
      stall_cnt       <= 4'd0;
      p.stall_timeout <= 1'b0;
    end else begin
      state           <= state_nx;
      stall_cnt       <= cnt_nx;
      p.stall_timeout <= p.stall_timeout | (cnt_nx >= MAX_CNT);
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p.of_ir    <= NOP_IR;
      p.of_pc    <= '0;
      p.of_valid <= 1'b0;
      p.ex_ir    <= NOP_IR;
      p.ex_pc    <= '0;
      p.ex_valid <= 1'b0;
    end else if (do_flush) begin
      p.of_ir    <= NOP_IR;
      p.of_pc    <= '0;
      p.of_valid <= 1'b0;
      p.ex_ir    <= NOP_IR;
      p.ex_pc    <= '0;
      p.ex_valid <= 1'b0;
    end else if (do_stall) begin
      p.ex_ir    <= NOP_IR;
      p.ex_pc    <= p.of_pc;
      p.ex_valid <= 1'b0;
    end else begin
      p.of_ir    <= p.if_ir;
      p.of_pc    <= p.if_pc;
      p.of_valid <= 1'b1;
      p.ex_ir    <= p.of_ir;
      p.ex_pc    <= p.of_pc;
      p.ex_valid <= p.of_valid;
    end
  end
`ifdef STALL_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      perf_stall_cycles <= 32'd0;
      perf_flush_events <= 32'd0;
    end else begin
      perf_stall_cycles <= perf_stall_cycles + {31'd0, do_stall};
      perf_flush_events <= perf_flush_events + {31'd0, do_flush};
    end
  end
`endif
endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// tb_pipeline_stall_ctrl: scoreboard bench; a two-slot pipeline model predicts every cycle's outputs.
module tb_pipeline_stall_ctrl;
  localparam logic [31:0] NOP = 32'h68000000;
  localparam int MAXS = 4;
  typedef struct {
    logic        pc_we;
    logic [31:0] of_ir, of_pc, ex_ir, ex_pc, ps, pf;
    logic        of_valid, ex_valid, stall, flush, tmo;
  } exp_t;
  logic clk = 1'b0;
  logic reset_n = 1'b1;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [31:0] m_of_ir, m_of_pc, m_ex_ir, m_ex_pc, m_ps, m_pf;
  logic m_of_valid, m_ex_valid, m_tmo;
  int run_len;
  logic [31:0] ps, pf;
  pipeline_stall_ctrl_if #(.XLEN(32)) bus ();
`ifdef STALL_PERF_CNT_EN
  pipeline_stall_ctrl #(.XLEN(32), .MAX_STALL(MAXS), .NOP_IR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .p(bus), .perf_stall_cycles(ps), .perf_flush_events(pf));
`else
  pipeline_stall_ctrl #(.XLEN(32), .MAX_STALL(MAXS), .NOP_IR(NOP)) dut (
    .clk(clk), .reset_n(reset_n), .p(bus));
  assign ps = 32'd0;
  assign pf = 32'd0;
`endif
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h exp %h", n, a, x);
    end
  endtask
  task automatic mreset();
    m_of_ir = NOP; m_of_pc = 0; m_of_valid = 0;
    m_ex_ir = NOP; m_ex_pc = 0; m_ex_valid = 0;
    m_tmo = 0; run_len = 0; m_ps = 0; m_pf = 0;
  endtask
  // Asserted at a negedge: outputs must clear with no clock edge, then release one cycle later.
  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_of_ir", bus.of_ir, NOP);
    chk("rst_ex_ir", bus.ex_ir, NOP);
    chk("rst_pcs", bus.of_pc | bus.ex_pc, 0);
    chk("rst_valids", {bus.of_valid, bus.ex_valid}, 0);
    chk("rst_flags", {bus.stall_o, bus.flush_o, bus.stall_timeout}, 0);
`ifdef STALL_PERF_CNT_EN
    chk("rst_perf", ps | pf, 0);
`endif
    mreset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask
  task automatic cyc(input logic il, input logic br, input logic [31:0] ir, input logic [31:0] pc);
    exp_t e;
    logic st;
    bus.is_data_interlock = il;
    bus.is_branch_taken = br;
    bus.if_ir = ir;
    bus.if_pc = pc;
    st = il && m_of_valid && !br;
    e.pc_we = !st;
    if (br) begin
      m_of_ir = NOP; m_of_pc = 0; m_of_valid = 0;
      m_ex_ir = NOP; m_ex_pc = 0; m_ex_valid = 0;
    end else if (st) begin
      m_ex_ir = NOP; m_ex_pc = m_of_pc; m_ex_valid = 0;
    end else begin
      m_ex_ir = m_of_ir; m_ex_pc = m_of_pc; m_ex_valid = m_of_valid;
      m_of_ir = ir; m_of_pc = pc; m_of_valid = 1;
    end
    run_len = st ? run_len + 1 : 0;
    if (run_len >= MAXS) m_tmo = 1;
    m_ps = m_ps + {31'd0, st};
    m_pf = m_pf + {31'd0, br};
    e.of_ir = m_of_ir; e.of_pc = m_of_pc; e.of_valid = m_of_valid;
    e.ex_ir = m_ex_ir; e.ex_pc = m_ex_pc; e.ex_valid = m_ex_valid;
    e.stall = st; e.flush = br; e.tmo = m_tmo; e.ps = m_ps; e.pf = m_pf;
    q.push_back(e);
    @(negedge clk);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("pc_we", bus.pc_we, e.pc_we);
        @(posedge clk);
        #1;
        chk("of_ir", bus.of_ir, e.of_ir);
        chk("of_pc", bus.of_pc, e.of_pc);
        chk("of_valid", bus.of_valid, e.of_valid);
        chk("ex_ir", bus.ex_ir, e.ex_ir);
        chk("ex_pc", bus.ex_pc, e.ex_pc);
        chk("ex_valid", bus.ex_valid, e.ex_valid);
        chk("stall_o", bus.stall_o, e.stall);
        chk("flush_o", bus.flush_o, e.flush);
        chk("stall_timeout", bus.stall_timeout, e.tmo);
`ifdef STALL_PERF_CNT_EN
        chk("perf_stall", ps, e.ps);
        chk("perf_flush", pf, e.pf);
`endif
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog q=%0d", q.size());
    $fatal(1, "timeout");
  end
  initial begin
    bus.is_data_interlock = 0;
    bus.is_branch_taken = 0;
    bus.if_ir = 0;
    bus.if_pc = 0;
    #1;
    do_reset();
    // load-use: ld then add, interlock for one cycle, add then reaches EX
    cyc(0, 0, 32'h7000_0001, 32'h100);
    cyc(0, 0, 32'h0000_1234, 32'h104);
    cyc(1, 0, 32'h0000_5678, 32'h108);
    cyc(0, 0, 32'h0000_5678, 32'h108);
    // branch taken together with interlock: flush wins
    cyc(1, 1, 32'h1111_1111, 32'h10c);
    // interlock against a squashed OF slot is ignored
    cyc(1, 0, 32'h2222_2222, 32'h200);
    // long interlock trips the sticky timeout
    cyc(0, 0, 32'h3333_3333, 32'h204);
    repeat (5) cyc(1, 0, 32'h4444_4444, 32'h208);
    cyc(0, 0, 32'h4444_4444, 32'h208);
    cyc(0, 0, 32'h5555_5555, 32'h20c);
    // reset while stalled
    cyc(1, 0, 32'h6666_6666, 32'h210);
    do_reset();
    for (int i = 0; i < 400; i++)
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, $urandom, $urandom);
    // reset while flushing
    cyc(0, 1, 32'h7777_7777, 32'h300);
    do_reset();
    cyc(0, 0, 32'h8888_8888, 32'h304);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    @(posedge clk);
    #3;
    chk("drain", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
